// File: rtl/game_pkg.sv
// Shared types and helpers for the maze game sequencer.
// Controller state codes, legacy 2-bit state codes and maze-size arithmetic.
package game_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_GEN  = 3'd1,
    S_PLAY = 3'd2,
    S_WIN  = 3'd3,
    S_FAIL = 3'd4
  } ctrl_state_t;

  typedef enum logic [1:0] {
    LEG_IDLE = 2'b00,
    LEG_PLAY = 2'b01,
    LEG_WIN  = 2'b10,
    LEG_FAIL = 2'b11
  } legacy_state_t;

  localparam logic [4:0] NUM_BASE = 5'd5;
  localparam logic [4:0] NUM_STEP = 5'd2;
  localparam logic [4:0] MAX_NUM  = 5'd19;

  function automatic logic [4:0] num_of(input logic [2:0] level);
    logic [4:0] n;
    n = NUM_BASE + NUM_STEP * {2'b00, level};
    return (n > MAX_NUM) ? MAX_NUM : n;
  endfunction

  // GEN shares the IDLE legacy code; older consumers never saw generation as a state.
  function automatic legacy_state_t legacy_of(input ctrl_state_t s);
    case (s)
      S_PLAY:  return LEG_PLAY;
      S_WIN:   return LEG_WIN;
      S_FAIL:  return LEG_FAIL;
      default: return LEG_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// Key, map-generator and player-status signals around the game sequencer.
// The sequencer uses the master view; peripherals and benches use the slave view.
interface game_ctrl_if;
  logic       up;
  logic       down;
  logic       enter;
  logic       gen_done;
  logic       arrived;
  logic       gen_start;
  logic [2:0] ctrl_state;
  logic [1:0] state;
  logic [2:0] level;
  logic [4:0] num;
  logic [7:0] time_left;
  logic       timer_run;
  logic       win;
  logic       fail;

  modport master (
    input  up, down, enter, gen_done, arrived,
    output gen_start, ctrl_state, state, level, num, time_left, timer_run, win, fail
  );

  modport slave (
    output up, down, enter, gen_done, arrived,
    input  gen_start, ctrl_state, state, level, num, time_left, timer_run, win, fail
  );
endinterface

// File: rtl/game_ctrl_tick_gen.sv
// Countdown prescaler: emits a tick on the last cycle of each TICK_CYCLES window while enabled.
// Counter holds when disabled and restarts from zero on clr.
module tick_gen #(
  parameter int unsigned TICK_CYCLES = 100_000_000
) (
  input  logic clk,
  input  logic rst_sys,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int unsigned CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst_sys || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/game_ctrl.sv
// Maze game sequencer: level select, map generation kick-off, countdown and WIN/FAIL decision.
// All outputs come straight from registers updated from a single next-state process.
module game_ctrl
  import game_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 100_000_000,
  parameter int unsigned TIME_BASE   = 60,
  parameter int unsigned TIME_STEP   = 15,
  parameter int unsigned MAX_LEVEL   = 7
) (
  input logic        clk,
  input logic        rst_sys,
  game_ctrl_if.master bus
);
  localparam logic [2:0] LEVEL_MAX = 3'(MAX_LEVEL);

  ctrl_state_t   state_q, state_d;
  legacy_state_t legacy_q, legacy_d;
  logic [2:0]    level_q, level_d;
  logic [4:0]    num_q, num_d;
  logic [7:0]    time_q, time_d;
  logic          gen_start_q, gen_start_d;
  logic          timer_run_q, timer_run_d;
  logic          win_q, win_d;
  logic          fail_q, fail_d;

  logic          tick;
  logic          tick_clr;
  logic [10:0]   step_prod;
  logic [11:0]   time_sum;
  logic [7:0]    time_init;

  tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick_gen (
    .clk    (clk),
    .rst_sys(rst_sys),
    .clr    (tick_clr),
    .en     (state_q == S_PLAY),
    .tick   (tick)
  );

  // Level budget: 11-bit product, then clamp the sum to the 8-bit counter range.
  always_comb begin
    step_prod = 11'(TIME_STEP) * {8'd0, level_q};
    time_sum  = 12'(TIME_BASE) + {1'b0, step_prod};
    time_init = (time_sum > 12'd255) ? 8'hFF : time_sum[7:0];
  end

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    time_d   = time_q;
    tick_clr = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.enter) begin
          state_d = S_GEN;
        end else if (bus.up && !bus.down) begin
          if (level_q < LEVEL_MAX) level_d = level_q + 3'd1;
        end else if (bus.down && !bus.up) begin
          if (level_q != 3'd0) level_d = level_q - 3'd1;
        end
      end
      S_GEN: begin
        if (bus.gen_done) begin
          state_d  = S_PLAY;
          time_d   = time_init;
          tick_clr = 1'b1;
        end
      end
      S_PLAY: begin
        if (tick) time_d = (time_q != 8'd0) ? time_q - 8'd1 : 8'd0;
        // Arrival beats the final tick, but the tick still takes its second.
        if (bus.arrived) begin
          state_d = S_WIN;
        end else if (tick && time_q <= 8'd1) begin
          state_d = S_FAIL;
        end
      end
      S_WIN: begin
        if (bus.enter) begin
          if (level_q < LEVEL_MAX) begin
            level_d = level_q + 3'd1;
            state_d = S_GEN;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_FAIL: begin
        if (bus.enter) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_IDLE) time_d = '0;

    gen_start_d = (state_d == S_GEN)  && (state_q != S_GEN);
    win_d       = (state_d == S_WIN)  && (state_q != S_WIN);
    fail_d      = (state_d == S_FAIL) && (state_q != S_FAIL);
    timer_run_d = (state_d == S_PLAY);
    num_d       = num_of(level_d);
    legacy_d    = legacy_of(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst_sys) begin
      state_q     <= S_IDLE;
      legacy_q    <= LEG_IDLE;
      level_q     <= '0;
      num_q       <= NUM_BASE;
      time_q      <= '0;
      gen_start_q <= 1'b0;
      timer_run_q <= 1'b0;
      win_q       <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      legacy_q    <= legacy_d;
      level_q     <= level_d;
      num_q       <= num_d;
      time_q      <= time_d;
      gen_start_q <= gen_start_d;
      timer_run_q <= timer_run_d;
      win_q       <= win_d;
      fail_q      <= fail_d;
    end
  end

  assign bus.ctrl_state = state_q;
  assign bus.state      = legacy_q;
  assign bus.level      = level_q;
  assign bus.num        = num_q;
  assign bus.time_left  = time_q;
  assign bus.gen_start  = gen_start_q;
  assign bus.timer_run  = timer_run_q;
  assign bus.win        = win_q;
  assign bus.fail       = fail_q;
endmodule
